// File: rtl/ad_dual_capture_if.sv
// Valid/ready stream carrying one formatted ADC sample pair per beat.
// Signals: out_data {chB,chA}, out_otr {otr_b,otr_a}, out_valid, out_ready, out_last.
// master: capture engine (drives data/otr/valid/last); slave: consumer (drives ready).
interface ad_dual_capture_if #(
    parameter int DATA_W = 10
);
    logic [2*DATA_W-1:0] out_data;
    logic [1:0]          out_otr;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output out_data,
        output out_otr,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_otr,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ad_dual_capture.sv
// Dual-channel ADC capture engine: lock qualification, pin registers, optional
// channel-A level trigger, decimated capture of sample pairs onto a valid/ready stream.
// Ports: ad_clk, rst_n (sync, active low), pll_lock (async), ad_data_a/b, ad_otr_a/b,
//   start, trig_mode, trig_level, decim, sample_num, stream (master),
//   adc_ready, busy, done, ovf, lock_err.
module ad_dual_capture #(
    parameter int DATA_W     = 10,
    parameter int CNT_W      = 16,
    parameter int LOCK_WAIT  = 1024,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic [DATA_W-1:0] ad_data_a,
    input  logic              ad_otr_a,
    input  logic [DATA_W-1:0] ad_data_b,
    input  logic              ad_otr_b,
    input  logic              start,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [7:0]        decim,
    input  logic [CNT_W-1:0]  sample_num,
    ad_dual_capture_if.master stream,
    output logic              adc_ready,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              lock_err
);

    localparam int LW = $clog2(LOCK_WAIT + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    state_t              state;
    logic                lock_m;
    logic                lock_s;
    logic [LW-1:0]       lock_cnt;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_b;
    logic                s1_otr_a;
    logic                s1_otr_b;
    logic [DATA_W-1:0]   prev_a;
    logic [7:0]          dcnt;
    logic [7:0]          decim_l;
    logic [CNT_W-1:0]    scnt;
    logic [CNT_W-1:0]    last_idx;

    logic trig_hit;
    logic accept;
    logic is_final;
    logic xfer;
    logic blocked;
    logic [7:0] dcnt_next;

    function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] raw);
        if (OFFSET_BIN) begin
            return {~raw[DATA_W-1], raw[DATA_W-2:0]};
        end
        return raw;
    endfunction

    // Rising crossing on the raw stage-1 channel A value.
    assign trig_hit  = (prev_a < trig_level) && (s1_a >= trig_level);
    assign accept    = ((state == CAPTURE) && (dcnt == 8'd0)) ||
                       ((state == ARMED) && trig_hit);
    assign is_final  = (scnt == last_idx);
    assign xfer      = stream.out_valid && stream.out_ready;
    assign blocked   = stream.out_valid && !stream.out_ready;
    // In ARMED dcnt is 0, so this also seeds the counter after a trigger.
    assign dcnt_next = (dcnt == decim_l) ? 8'd0 : dcnt + 8'd1;

    assign adc_ready = (state != WAIT_LOCK);
    assign busy      = (state == ARMED) || (state == CAPTURE);

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            lock_m   <= 1'b0;
            lock_s   <= 1'b0;
            lock_cnt <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_otr_a <= 1'b0;
            s1_otr_b <= 1'b0;
            prev_a   <= '0;
        end else begin
            lock_m   <= pll_lock;
            lock_s   <= lock_m;
            if (!lock_s) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LW'(LOCK_WAIT)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            s1_a     <= ad_data_a;
            s1_b     <= ad_data_b;
            s1_otr_a <= ad_otr_a;
            s1_otr_b <= ad_otr_b;
            prev_a   <= s1_a;
        end
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state            <= WAIT_LOCK;
            dcnt             <= '0;
            decim_l          <= '0;
            scnt             <= '0;
            last_idx         <= '0;
            done             <= 1'b0;
            ovf              <= 1'b0;
            lock_err         <= 1'b0;
            stream.out_data  <= '0;
            stream.out_otr   <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!lock_s) begin
                state <= WAIT_LOCK;
                if (busy) begin
                    lock_err         <= 1'b1;
                    stream.out_valid <= 1'b0;
                end else if (xfer) begin
                    stream.out_valid <= 1'b0;
                end
            end else begin
                // Dropped samples still advance the count so timing is preserved.
                if (accept && !blocked) begin
                    stream.out_data  <= {fmt(s1_b), fmt(s1_a)};
                    stream.out_otr   <= {s1_otr_b, s1_otr_a};
                    stream.out_last  <= is_final;
                    stream.out_valid <= 1'b1;
                end else if (accept) begin
                    ovf <= 1'b1;
                end else if (xfer) begin
                    stream.out_valid <= 1'b0;
                end

                unique case (state)
                    WAIT_LOCK: begin
                        if (lock_cnt == LW'(LOCK_WAIT)) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (start) begin
                            decim_l  <= decim;
                            last_idx <= (sample_num == '0) ? '0
                                                           : sample_num - 1'b1;
                            scnt     <= '0;
                            dcnt     <= '0;
                            ovf      <= 1'b0;
                            lock_err <= 1'b0;
                            state    <= trig_mode ? ARMED : CAPTURE;
                        end
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            dcnt <= dcnt_next;
                            scnt <= scnt + 1'b1;
                            if (is_final) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        dcnt <= dcnt_next;
                        if (dcnt == 8'd0) begin
                            scnt <= scnt + 1'b1;
                            if (is_final) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_dual_capture.sv
// Scoreboard bench for ad_dual_capture: directed captures push expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_ad_dual_capture;

    localparam int L = 8;

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic        pll_lock;
    logic [9:0]  ad_data_a;
    logic        ad_otr_a;
    logic [9:0]  ad_data_b;
    logic        ad_otr_b;
    logic        start;
    logic        trig_mode;
    logic [9:0]  trig_level;
    logic [7:0]  decim;
    logic [15:0] sample_num;
    logic        adc_ready;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        lock_err;

    ad_dual_capture_if #(.DATA_W(10)) stream ();

    ad_dual_capture #(
        .DATA_W(10), .CNT_W(16), .LOCK_WAIT(L), .OFFSET_BIN(1'b1)
    ) dut (
        .ad_clk(ad_clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .ad_data_a(ad_data_a), .ad_otr_a(ad_otr_a),
        .ad_data_b(ad_data_b), .ad_otr_b(ad_otr_b),
        .start(start), .trig_mode(trig_mode), .trig_level(trig_level),
        .decim(decim), .sample_num(sample_num), .stream(stream),
        .adc_ready(adc_ready), .busy(busy), .done(done),
        .ovf(ovf), .lock_err(lock_err)
    );

    always #5 ad_clk = ~ad_clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit ramp_on = 1'b0;
    logic [22:0] expq[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Offset binary to two's complement: flip the MSB.
    function automatic logic [9:0] fmt(input logic [9:0] v);
        return v ^ 10'h200;
    endfunction

    function automatic logic [19:0] pair(input logic [9:0] v);
        logic [9:0] b;
        b = v + 10'd3;
        return {fmt(b), fmt(v)};
    endfunction

    function automatic logic [22:0] beat(input logic [9:0] v, input bit last);
        logic [9:0] b;
        b = v + 10'd3;
        return {pair(v), b[3], v[2], last};
    endfunction

    task automatic set_a(input logic [9:0] v);
        ad_data_a = v;
        ad_data_b = v + 10'd3;
        ad_otr_a  = v[2];
        ad_otr_b  = ad_data_b[3];
    endtask

    task automatic cyc();
        @(posedge ad_clk);
        #1;
        if (ramp_on) set_a(ad_data_a + 10'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            cyc();
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_ready(input string name, input int max);
        int n;
        n = 0;
        while (!adc_ready && n < max) begin
            cyc();
            n++;
        end
        check(name, {31'd0, adc_ready}, 32'd1);
    endtask

    always @(posedge ad_clk) begin
        if (rst_n && done) done_cnt++;
    end

    always @(negedge ad_clk) begin
        if (rst_n && stream.out_valid && stream.out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, none expected",
                         stream.out_data, stream.out_last);
            end else begin
                check("beat",
                      {9'd0, stream.out_data, stream.out_otr, stream.out_last},
                      {9'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] a0;
        int n;
        int dc;

        rst_n = 1'b0;
        pll_lock = 1'b0;
        start = 1'b0;
        trig_mode = 1'b0;
        trig_level = 10'd512;
        decim = 8'd0;
        sample_num = 16'd8;
        stream.out_ready = 1'b1;
        set_a(10'd0);
        repeat (3) cyc();

        check("rst_valid", {31'd0, stream.out_valid}, 32'd0);
        check("rst_data", {12'd0, stream.out_data}, 32'd0);
        check("rst_last", {31'd0, stream.out_last}, 32'd0);
        check("rst_flags", {27'd0, adc_ready, busy, done, ovf, lock_err}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Lock held one cycle short of qualifying, then dropped.
        pll_lock = 1'b1;
        repeat (L - 1) cyc();
        pll_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("lock_short", {31'd0, adc_ready}, 32'd0);
        end
        pll_lock = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!adc_ready && n < 50);
        check("lock_latency", n, L + 3);

        // Immediate capture, 8 back-to-back beats.
        ramp_on = 1'b1;
        a0 = ad_data_a;
        for (int k = 0; k < 8; k++) expq.push_back(beat(a0 + 10'(k), k == 7));
        pulse_start();
        repeat (6) cyc();
        check("busy_capture", {31'd0, busy}, 32'd1);
        cyc();
        check("done_early", {31'd0, done}, 32'd0);
        cyc();
        check("done_pulse", {31'd0, done}, 32'd1);
        cyc();
        check("done_width", {31'd0, done}, 32'd0);
        check("ovf_clean", {31'd0, ovf}, 32'd0);
        repeat (3) cyc();

        // Decimation by 4.
        decim = 8'd3;
        sample_num = 16'd4;
        a0 = ad_data_a;
        for (int k = 0; k < 4; k++) expq.push_back(beat(a0 + 10'(4 * k), k == 3));
        pulse_start();
        wait_done("decim_done", 40);
        repeat (3) cyc();

        // Triggered capture on a ramp crossing 512.
        decim = 8'd0;
        sample_num = 16'd2;
        trig_mode = 1'b1;
        set_a(10'd500);
        expq.push_back(beat(10'd512, 1'b0));
        expq.push_back(beat(10'd513, 1'b1));
        pulse_start();
        wait_done("trig_done", 40);
        repeat (3) cyc();

        // Level stays above threshold: must stay armed.
        ramp_on = 1'b0;
        set_a(10'd600);
        sample_num = 16'd1;
        repeat (3) cyc();
        pulse_start();
        repeat (10) cyc();
        check("armed_hold", {30'd0, busy, done}, 32'd2);
        set_a(10'd0);
        cyc();
        expq.push_back(beat(10'd600, 1'b1));
        set_a(10'd600);
        wait_done("retrig_done", 10);
        repeat (3) cyc();

        // Backpressure mid-capture.
        ramp_on = 1'b1;
        trig_mode = 1'b0;
        sample_num = 16'd8;
        a0 = ad_data_a;
        expq.push_back(beat(a0, 1'b0));
        expq.push_back(beat(a0 + 10'd1, 1'b0));
        expq.push_back(beat(a0 + 10'd5, 1'b0));
        expq.push_back(beat(a0 + 10'd6, 1'b0));
        expq.push_back(beat(a0 + 10'd7, 1'b1));
        pulse_start();
        cyc();
        cyc();
        stream.out_ready = 1'b0;
        cyc();
        cyc();
        check("hold_data", {12'd0, stream.out_data}, {12'd0, pair(a0 + 10'd1)});
        check("hold_valid", {31'd0, stream.out_valid}, 32'd1);
        cyc();
        stream.out_ready = 1'b1;
        check("ovf_set", {31'd0, ovf}, 32'd1);
        cyc();
        cyc();
        cyc();
        check("bp_done", {31'd0, done}, 32'd1);
        repeat (3) cyc();

        // Lock loss during capture.
        a0 = ad_data_a;
        for (int k = 0; k < 4; k++) expq.push_back(beat(a0 + 10'(k), 1'b0));
        dc = done_cnt;
        pulse_start();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        cyc();
        cyc();
        pll_lock = 1'b0;
        cyc();
        cyc();
        cyc();
        check("abort_valid", {31'd0, stream.out_valid}, 32'd0);
        check("abort_err", {31'd0, lock_err}, 32'd1);
        check("abort_state", {30'd0, adc_ready, busy}, 32'd0);
        repeat (4) cyc();
        check("abort_nodone", done_cnt, dc);
        pll_lock = 1'b1;
        wait_ready("relock", 30);

        // Restart clears lock_err; sample_num 0 behaves as 1.
        sample_num = 16'd0;
        a0 = ad_data_a;
        expq.push_back(beat(a0, 1'b1));
        pulse_start();
        check("err_cleared", {31'd0, lock_err}, 32'd0);
        wait_done("single_done", 10);
        repeat (5) cyc();

        check("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
